div19sx8s: RTL

Sequential signed divider: 19-bit signed dividend by 8-bit signed divisor, giving an 11-bit signed quotient and an 8-bit signed remainder. It is the inverse of the 11s×8s product path in the DCTQ datapath. It recovers coefficients from scaled products, for example in quantiser/dequantiser cross-checks. It uses sign-magnitude arithmetic and a radix-2 restoring iteration, one quotient bit per cycle. A valid/ready handshake sits on both the input and output sides.

---
 rtl/div19sx8s_if.sv | 52 +++++
 rtl/div19sx8s.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div19sx8s_if.sv
// ============================================================================
// Module      : div19sx8s_if
// Description : Operand/result handshake bundle for the 19s/8s divider.
//               The master side presents operands and accepts results; the
//               slave side is the divider itself.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div19sx8s_if;
    // Input side: operands offered with valid/ready
    logic              in_valid;
    logic              in_ready;
    logic [18:0]       dividend;
    logic [7:0]        divisor;

    // Output side: result held with valid/ready
    logic              out_valid;
    logic              out_ready;
    logic [10:0]       quotient;
    logic [7:0]        remainder;
    logic              overflow;
    logic              div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  overflow,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output overflow,
        output div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/div19sx8s.sv
// ============================================================================
// Module      : div19sx8s
// Description : Sequential signed divider, 19-bit dividend by 8-bit divisor.
//               Sign-magnitude, radix-2 restoring iteration (one quotient bit
//               per cycle). Produces an 11-bit saturated quotient truncated
//               toward zero, an 8-bit remainder carrying the dividend sign,
//               and overflow / divide-by-zero flags.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div19sx8s (
    input  wire logic   clk,
    input  wire logic   rst_n,
    div19sx8s_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [10:0] Q_MAX      = 11'h3FF;   // +1023
    localparam logic [10:0] Q_MIN      = 11'h400;   // -1024
    localparam logic [18:0] POS_LIMIT  = 19'd1023;
    localparam logic [18:0] NEG_LIMIT  = 19'd1024;
    localparam logic [4:0]  ITER_LAST  = 5'd18;     // 19 iterations: 18..0

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t       state_q,       state_d;
    logic         sgn_dd_q,      sgn_dd_d;      // dividend sign
    logic         sgn_dv_q,      sgn_dv_d;      // divisor sign
    logic [18:0]  dd_mag_q,      dd_mag_d;      // dividend magnitude, shifted out MSB first
    logic [7:0]   dv_mag_q,      dv_mag_d;      // divisor magnitude (128 fits)
    logic         dd_zero_q,     dd_zero_d;
    logic         dv_zero_q,     dv_zero_d;
    logic [8:0]   part_q,        part_d;        // partial remainder
    logic [4:0]   cnt_q,         cnt_d;         // iterations left
    logic [18:0]  quo_mag_q,     quo_mag_d;     // quotient magnitude

    // Registered result outputs
    logic [10:0]  quotient_q,    quotient_d;
    logic [7:0]   remainder_q,   remainder_d;
    logic         overflow_q,    overflow_d;
    logic         div_by_zero_q, div_by_zero_d;
    logic         out_valid_q,   out_valid_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [18:0]  w_dd_abs;
    logic [7:0]   w_dv_abs;
    logic [9:0]   w_trial;
    logic [9:0]   w_diff;
    logic         w_ge;
    logic         w_q_neg;
    logic [7:0]   w_rem_mag;
    logic [10:0]  fin_quo;
    logic [7:0]   fin_rem;
    logic         fin_ovf;
    logic         fin_dbz;

    // Operand magnitudes; the most negative codes map to 2^18 and 128
    always_comb begin
        w_dd_abs = bus.dividend[18] ? (~bus.dividend + 19'd1) : bus.dividend;
        w_dv_abs = bus.divisor[7]   ? (~bus.divisor  + 8'd1)  : bus.divisor;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // While the divisor is nonzero the partial stays below it (<=127), so the
    // trial is at most 255 and bit 9 of the difference is a clean borrow flag.
    always_comb begin
        w_trial = {part_q, dd_mag_q[18]};
        w_diff  = w_trial - {2'b00, dv_mag_q};
        w_ge    = ~w_diff[9];
    end

    // Result formatting: sign application, saturation and special operands
    always_comb begin
        fin_quo   = 11'd0;
        fin_rem   = 8'd0;
        fin_ovf   = 1'b0;
        fin_dbz   = 1'b0;
        w_q_neg   = sgn_dd_q ^ sgn_dv_q;
        w_rem_mag = part_q[7:0];
        if (dv_zero_q) begin
            // Zero divisor wins over zero dividend: saturate toward the dividend sign
            fin_dbz = 1'b1;
            fin_quo = sgn_dd_q ? Q_MIN : Q_MAX;
        end else if (dd_zero_q) begin
            fin_quo = 11'd0;
        end else begin
            fin_rem = sgn_dd_q ? (~w_rem_mag + 8'd1) : w_rem_mag;
            if (w_q_neg) begin
                if (quo_mag_q > NEG_LIMIT) begin
                    fin_quo = Q_MIN;
                    fin_ovf = 1'b1;
                end else begin
                    // A magnitude of exactly 1024 negates to the -1024 code
                    fin_quo = ~quo_mag_q[10:0] + 11'd1;
                end
            end else begin
                if (quo_mag_q > POS_LIMIT) begin
                    fin_quo = Q_MAX;
                    fin_ovf = 1'b1;
                end else begin
                    fin_quo = quo_mag_q[10:0];
                end
            end
        end
    end

    // Next-state and next-datapath selection for the four-state controller
    always_comb begin
        state_d       = state_q;
        sgn_dd_d      = sgn_dd_q;
        sgn_dv_d      = sgn_dv_q;
        dd_mag_d      = dd_mag_q;
        dv_mag_d      = dv_mag_q;
        dd_zero_d     = dd_zero_q;
        dv_zero_d     = dv_zero_q;
        part_d        = part_q;
        cnt_d         = cnt_q;
        quo_mag_d     = quo_mag_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        out_valid_d   = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sgn_dd_d  = bus.dividend[18];
                    sgn_dv_d  = bus.divisor[7];
                    dd_mag_d  = w_dd_abs;
                    dv_mag_d  = w_dv_abs;
                    dd_zero_d = (bus.dividend == 19'd0);
                    dv_zero_d = (bus.divisor == 8'd0);
                    part_d    = 9'd0;
                    quo_mag_d = 19'd0;
                    cnt_d     = ITER_LAST;
                    state_d   = DIVIDE;
                end
            end

            DIVIDE: begin
                dd_mag_d  = {dd_mag_q[17:0], 1'b0};
                part_d    = w_ge ? w_diff[8:0] : w_trial[8:0];
                quo_mag_d = {quo_mag_q[17:0], w_ge};
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            FINISH: begin
                quotient_d    = fin_quo;
                remainder_d   = fin_rem;
                overflow_d    = fin_ovf;
                div_by_zero_d = fin_dbz;
                out_valid_d   = 1'b1;
                state_d       = HOLD;
            end

            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register all state; asynchronous reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sgn_dd_q      <= 1'b0;
            sgn_dv_q      <= 1'b0;
            dd_mag_q      <= 19'd0;
            dv_mag_q      <= 8'd0;
            dd_zero_q     <= 1'b0;
            dv_zero_q     <= 1'b0;
            part_q        <= 9'd0;
            cnt_q         <= 5'd0;
            quo_mag_q     <= 19'd0;
            quotient_q    <= 11'd0;
            remainder_q   <= 8'd0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sgn_dd_q      <= sgn_dd_d;
            sgn_dv_q      <= sgn_dv_d;
            dd_mag_q      <= dd_mag_d;
            dv_mag_q      <= dv_mag_d;
            dd_zero_q     <= dd_zero_d;
            dv_zero_q     <= dv_zero_d;
            part_q        <= part_d;
            cnt_q         <= cnt_d;
            quo_mag_q     <= quo_mag_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Outputs: in_ready decodes the state only, everything else is a flop
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = out_valid_q;
        bus.quotient    = quotient_q;
        bus.remainder   = remainder_q;
        bus.overflow    = overflow_q;
        bus.div_by_zero = div_by_zero_q;
    end

endmodule

`default_nettype wire
